// File: rtl/sn76489_bus_writer_if.sv
// Bundle of request handshake and PSG write-port signals for sn76489_bus_writer.
// The master modport is the bus writer itself: it consumes requests and drives
// the PSG strobes. The slave modport is its environment (bus decode plus PSG).
interface sn76489_bus_writer_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_kind;
  logic [1:0] req_chan;
  logic [9:0] req_value;
  logic [7:0] d;
  logic       nCE;
  logic       nWE;
  logic       psg_ready;
  logic       done;
  logic       err_illegal;
  logic       err_timeout;

  modport master (
    input  req_valid, req_kind, req_chan, req_value, psg_ready,
    output req_ready, d, nCE, nWE, done, err_illegal, err_timeout
  );

  modport slave (
    output req_valid, req_kind, req_chan, req_value, psg_ready,
    input  req_ready, d, nCE, nWE, done, err_illegal, err_timeout
  );
endinterface

// File: rtl/sn76489_bus_writer.sv
// CPU-side writer for the SN76489 PSG data port.
// Turns one register-update request into one or two PSG bytes and plays them
// out with the strobe / wait-for-ready / recover handshake the PSG expects.
module sn76489_bus_writer #(
  parameter int RECOVERY_CYCLES = 2,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input logic                  clock,
  input logic                  reset,
  sn76489_bus_writer_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_HOLD,
    ST_RELEASE
  } state_t;

  localparam logic [1:0] KIND_FREQ        = 2'd0;
  localparam logic [1:0] KIND_ATTEN       = 2'd1;
  localparam logic [1:0] KIND_NOISE_CTRL  = 2'd2;

  localparam logic [7:0] TIMEOUT_LAST  = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] RECOVERY_LAST = 8'(RECOVERY_CYCLES - 1);

  state_t     state;
  logic [7:0] data_reg;
  logic       ce_n_reg;
  logic       we_n_reg;
  logic       done_reg;
  logic       illegal_reg;
  logic       timeout_reg;
  logic [7:0] timeout_cnt;
  logic [7:0] recovery_cnt;
  logic       pending;
  logic [7:0] pending_byte;
  logic       aborted;

  logic       ready;
  logic       accept;
  logic [2:0] reg_code;
  logic [3:0] hi_nibble;
  logic       illegal;
  logic       two_bytes;
  logic [7:0] first_byte;
  logic [7:0] second_byte;

  assign ready  = (state == ST_IDLE) && !reset;
  assign accept = bus.req_valid && ready;

  // Map the incoming request onto a PSG register code and the high nibble of byte 1.
  always_comb begin
    reg_code  = 3'd0;
    hi_nibble = 4'd0;
    illegal   = 1'b0;
    two_bytes = 1'b0;
    case (bus.req_kind)
      KIND_FREQ: begin
        hi_nibble = bus.req_value[9:6];
        two_bytes = 1'b1;
        case (bus.req_chan)
          2'd0:    reg_code = 3'd0;
          2'd1:    reg_code = 3'd2;
          2'd2:    reg_code = 3'd1;
          default: illegal  = 1'b1;
        endcase
      end
      KIND_ATTEN: begin
        hi_nibble = bus.req_value[3:0];
        case (bus.req_chan)
          2'd0:    reg_code = 3'd4;
          2'd1:    reg_code = 3'd6;
          2'd2:    reg_code = 3'd5;
          default: illegal  = 1'b1;
        endcase
      end
      KIND_NOISE_CTRL: begin
        reg_code  = 3'd3;
        hi_nibble = {bus.req_value[2:1], bus.req_value[0], 1'b0};
      end
      default: begin
        reg_code  = 3'd7;
        hi_nibble = bus.req_value[3:0];
      end
    endcase
  end

  assign first_byte  = {hi_nibble, reg_code, 1'b1};
  assign second_byte = {bus.req_value[5:0], 2'b00};

  // Transfer sequencer: strobe a byte, wait for the PSG busy cycle, then recover.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      data_reg     <= 8'h00;
      ce_n_reg     <= 1'b1;
      we_n_reg     <= 1'b1;
      done_reg     <= 1'b0;
      illegal_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
      timeout_cnt  <= 8'd0;
      recovery_cnt <= 8'd0;
      pending      <= 1'b0;
      pending_byte <= 8'h00;
      aborted      <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      illegal_reg <= 1'b0;
      timeout_reg <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (illegal) begin
              illegal_reg <= 1'b1;
            end else begin
              data_reg     <= first_byte;
              pending      <= two_bytes;
              pending_byte <= second_byte;
              aborted      <= 1'b0;
              timeout_cnt  <= 8'd0;
              ce_n_reg     <= 1'b0;
              we_n_reg     <= 1'b0;
              state        <= ST_STROBE;
            end
          end
        end
        ST_STROBE: begin
          if (timeout_cnt == TIMEOUT_LAST) begin
            timeout_reg  <= 1'b1;
            pending      <= 1'b0;
            aborted      <= 1'b1;
            ce_n_reg     <= 1'b1;
            we_n_reg     <= 1'b1;
            recovery_cnt <= 8'd0;
            state        <= ST_RELEASE;
          end else begin
            timeout_cnt <= timeout_cnt + 8'd1;
            if (!bus.psg_ready) begin
              state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (timeout_cnt == TIMEOUT_LAST) begin
            timeout_reg  <= 1'b1;
            pending      <= 1'b0;
            aborted      <= 1'b1;
            ce_n_reg     <= 1'b1;
            we_n_reg     <= 1'b1;
            recovery_cnt <= 8'd0;
            state        <= ST_RELEASE;
          end else if (bus.psg_ready) begin
            ce_n_reg     <= 1'b1;
            we_n_reg     <= 1'b1;
            recovery_cnt <= 8'd0;
            state        <= ST_RELEASE;
          end else begin
            timeout_cnt <= timeout_cnt + 8'd1;
          end
        end
        ST_RELEASE: begin
          if (recovery_cnt == RECOVERY_LAST) begin
            if (pending) begin
              data_reg    <= pending_byte;
              pending     <= 1'b0;
              timeout_cnt <= 8'd0;
              ce_n_reg    <= 1'b0;
              we_n_reg    <= 1'b0;
              state       <= ST_STROBE;
            end else begin
              done_reg <= !aborted;
              state    <= ST_IDLE;
            end
          end else begin
            recovery_cnt <= recovery_cnt + 8'd1;
          end
        end
        default: begin
          ce_n_reg <= 1'b1;
          we_n_reg <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = ready;
  assign bus.d           = data_reg;
  assign bus.nCE         = ce_n_reg;
  assign bus.nWE         = we_n_reg;
  assign bus.done        = done_reg;
  assign bus.err_illegal = illegal_reg;
  assign bus.err_timeout = timeout_reg;

endmodule

// File: tb/tb_sn76489_bus_writer.sv
// Self-checking bench for sn76489_bus_writer: directed steps followed by random
// requests, compared against a request-level model and a simple PSG model.
module tb_sn76489_bus_writer;

  localparam int RECOVERY = 2;
  localparam int TIMEOUT  = 255;

  logic clock = 1'b0;
  logic reset = 1'b1;

  sn76489_bus_writer_if bus ();

  sn76489_bus_writer #(
    .RECOVERY_CYCLES(RECOVERY),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock
  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  // PSG model state
  bit         psg_present  = 1'b1;
  int         psg_busy_len = 1;
  int         busy_left    = 0;
  bit         psg_took     = 1'b0;
  logic [2:0] psg_latch    = 3'd7;
  logic [9:0] psg_tone [0:7];

  // Bus monitor state
  logic [7:0] seen_bytes[$];
  logic [7:0] strobe_d      = 8'h00;
  logic       prev_nce      = 1'b1;
  logic       prev_done     = 1'b0;
  bit         any_strobe    = 1'b0;
  int         low_run       = 0;
  int         high_run      = 0;
  int         last_low_run  = 0;
  int         done_cnt      = 0;
  int         proto_err     = 0;

  // Reference bookkeeping
  int         exp_done_total = 0;
  int         exp_tone [0:2];
  logic [15:0] last_pair;
  int         lat;
  int         snap;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // PSG register file as the chip would see the byte stream
  task automatic psg_decode(input logic [7:0] b);
    if (b[0]) begin
      psg_latch = b[3:1];
      if (b[3:1] <= 3'd2) psg_tone[b[3:1]][9:6] = b[7:4];
    end else if (psg_latch <= 3'd2) begin
      psg_tone[psg_latch][5:0] = b[7:2];
    end
  endtask

  // PSG model: goes busy for psg_busy_len cycles after seeing a write strobe
  always @(negedge clock) begin
    if (bus.nCE === 1'b1) psg_took = 1'b0;
    if (!psg_present) begin
      busy_left     = 0;
      bus.psg_ready = 1'b1;
    end else if (busy_left > 0) begin
      busy_left--;
      bus.psg_ready = (busy_left == 0);
    end else if (!psg_took && bus.nCE === 1'b0 && bus.nWE === 1'b0) begin
      psg_took      = 1'b1;
      busy_left     = psg_busy_len;
      bus.psg_ready = 1'b0;
      psg_decode(bus.d);
    end else begin
      bus.psg_ready = 1'b1;
    end
  end

  // Bus monitor: captures strobed bytes and tracks protocol rules
  always @(negedge clock) begin
    if (bus.nWE === 1'b0 && bus.nCE === 1'b1) proto_err++;
    if (bus.req_ready === 1'b1 && bus.nCE === 1'b0) proto_err++;
    if (bus.nCE === 1'b0) begin
      if (prev_nce === 1'b1) begin
        seen_bytes.push_back(bus.d);
        strobe_d = bus.d;
        if (any_strobe && high_run < RECOVERY) proto_err++;
        any_strobe = 1'b1;
        low_run    = 0;
      end else if (bus.d !== strobe_d) begin
        proto_err++;
      end
      low_run++;
      high_run = 0;
    end else begin
      if (prev_nce === 1'b0) last_low_run = low_run;
      high_run++;
    end
    prev_nce = bus.nCE;
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (prev_done === 1'b1) proto_err++;
    end
    prev_done = bus.done;
  end

  // Expected bytes and outcome of one request (0 done, 1 illegal, 2 timeout)
  function automatic void model_request(input int kind, input int chan, input int value, input bit present,
                                        output int nbytes, output logic [15:0] pair, output int outcome);
    int tone_code [0:2];
    int reg_code, hi, first, second;
    tone_code = '{0, 2, 1};
    reg_code  = 0;
    hi        = 0;
    nbytes    = 0;
    pair      = 16'h0000;
    outcome   = 1;
    if (kind <= 1 && chan == 3) return;
    case (kind)
      0:       begin reg_code = tone_code[chan];     hi = value / 64; end
      1:       begin reg_code = tone_code[chan] + 4; hi = value % 16; end
      2:       begin reg_code = 3; hi = ((value / 2) % 4) * 4 + (value % 2) * 2; end
      default: begin reg_code = 7; hi = value % 16; end
    endcase
    first  = hi * 16 + reg_code * 2 + 1;
    second = (value % 64) * 4;
    if (!present) begin
      nbytes = 1; pair = 16'(first * 256); outcome = 2;
    end else if (kind == 0) begin
      nbytes = 2; pair = 16'(first * 256 + second); outcome = 0;
    end else begin
      nbytes = 1; pair = 16'(first * 256); outcome = 0;
    end
  endfunction

  task automatic wait_ready(input string tag);
    int waited;
    waited = 0;
    @(negedge clock);
    while (bus.req_ready !== 1'b1 && waited < 2000) begin
      @(negedge clock);
      waited++;
    end
    check_output({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic drive_request(input int kind, input int chan, input int value);
    bus.req_valid = 1'b1;
    bus.req_kind  = 2'(kind);
    bus.req_chan  = 2'(chan);
    bus.req_value = 10'(value);
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    bus.req_kind  = 2'($urandom);
    bus.req_chan  = 2'($urandom);
    bus.req_value = 10'($urandom);
  endtask

  task automatic apply_stimulus(input string tag, input int kind, input int chan, input int value,
                                input bit present, input int busy, output int latency);
    int          exp_n, exp_outcome, obs_outcome;
    logic [15:0] exp_pair, obs_pair;
    model_request(kind, chan, value, present, exp_n, exp_pair, exp_outcome);
    psg_present  = present;
    psg_busy_len = busy;
    seen_bytes.delete();
    wait_ready(tag);
    drive_request(kind, chan, value);
    obs_outcome = 3;
    latency     = 0;
    while (obs_outcome == 3 && latency < 3000) begin
      @(negedge clock);
      latency++;
      if (bus.done === 1'b1)             obs_outcome = 0;
      else if (bus.err_illegal === 1'b1) obs_outcome = 1;
      else if (bus.err_timeout === 1'b1) obs_outcome = 2;
    end
    check_output({tag, "_outcome"}, 32'(obs_outcome), 32'(exp_outcome));
    check_output({tag, "_nce_at_end"}, 32'(bus.nCE), 32'd1);
    check_output({tag, "_ready_at_end"}, 32'(bus.req_ready), 32'(exp_outcome != 2));
    obs_pair = 16'h0000;
    if (seen_bytes.size() > 0) obs_pair[15:8] = seen_bytes[0];
    if (seen_bytes.size() > 1) obs_pair[7:0]  = seen_bytes[1];
    check_output({tag, "_nbytes"}, 32'(seen_bytes.size()), 32'(exp_n));
    check_output({tag, "_bytes"}, 32'(obs_pair), 32'(exp_pair));
    @(negedge clock);
    check_output({tag, "_pulse_end"}, 32'({bus.done, bus.err_illegal, bus.err_timeout}), 32'd0);
    if (exp_outcome == 0) exp_done_total++;
    if (kind == 0 && exp_outcome == 0) exp_tone[chan] = value;
    last_pair = obs_pair;
  endtask

  // Hard stop in case something never completes
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed steps followed by a randomized sequence
  initial begin
    bus.req_valid = 1'b0;
    bus.req_kind  = 2'd0;
    bus.req_chan  = 2'd0;
    bus.req_value = 10'd0;
    exp_tone      = '{0, 0, 0};

    // Power-on reset
    repeat (3) @(posedge clock);
    #1;
    check_output("por_nce", 32'(bus.nCE), 32'd1);
    check_output("por_nwe", 32'(bus.nWE), 32'd1);
    check_output("por_d", 32'(bus.d), 32'h00);
    check_output("por_ready_in_reset", 32'(bus.req_ready), 32'd0);
    check_output("por_pulses", 32'({bus.done, bus.err_illegal, bus.err_timeout}), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Reset asserted while a byte is in HOLD
    psg_present  = 1'b1;
    psg_busy_len = 31;
    wait_ready("rsthold");
    drive_request(0, 0, 10'h155);
    repeat (4) @(negedge clock);
    check_output("rsthold_nce_low", 32'(bus.nCE), 32'd0);
    check_output("rsthold_psg_busy", 32'(bus.psg_ready), 32'd0);
    snap  = done_cnt;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_output("rsthold_nce", 32'(bus.nCE), 32'd1);
    check_output("rsthold_nwe", 32'(bus.nWE), 32'd1);
    check_output("rsthold_d", 32'(bus.d), 32'h00);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_output("rsthold_ready_after", 32'(bus.req_ready), 32'd1);
    repeat (40) @(negedge clock);
    check_output("rsthold_no_done", 32'(done_cnt), 32'(snap));

    // Tone frequency, channel 0, slow PSG
    apply_stimulus("freq0", 0, 0, 10'h2A5, 1'b1, 31, lat);
    check_output("freq0_lit", 32'(last_pair), 32'hA194);
    check_output("freq0_psg", 32'(psg_tone[0]), 32'h2A5);

    // Single-byte kinds
    apply_stimulus("atten1", 1, 1, 10'h00B, 1'b1, 3, lat);
    check_output("atten1_lit", 32'(last_pair), 32'hBD00);
    apply_stimulus("noisectl", 2, 0, 10'h005, 1'b1, 2, lat);
    check_output("noisectl_lit", 32'(last_pair), 32'hA700);

    // Remaining tone channels, then back-to-back noise attenuation
    apply_stimulus("freq1", 0, 1, int'($urandom_range(0, 1023)), 1'b1, 4, lat);
    apply_stimulus("freq2", 0, 2, 10'h3FF, 1'b1, 5, lat);
    check_output("freq2_lit", 32'(last_pair), 32'hF3FC);
    check_output("freq2_psg", 32'(psg_tone[1]), 32'h3FF);
    apply_stimulus("nzatten", 3, 2, 10'h000, 1'b1, 1, lat);
    check_output("nzatten_lit", 32'(last_pair), 32'h0F00);

    // Illegal channel for an attenuation request
    apply_stimulus("illegal", 1, 3, 10'h00F, 1'b1, 2, lat);
    check_output("illegal_latency", 32'(lat), 32'd1);

    // No PSG answering: first byte times out, second never appears
    apply_stimulus("timeout", 0, int'($urandom_range(0, 2)), int'($urandom_range(0, 1023)), 1'b0, 1, lat);
    check_output("timeout_strobe_len", 32'(last_low_run), 32'(TIMEOUT));
    snap = done_cnt;
    repeat (RECOVERY + 4) @(negedge clock);
    @(posedge clock);
    #1;
    check_output("timeout_no_done", 32'(done_cnt), 32'(snap));
    check_output("timeout_ready_back", 32'(bus.req_ready), 32'd1);
    check_output("timeout_one_byte", 32'(seen_bytes.size()), 32'd1);

    // Randomized requests
    for (int i = 0; i < 24; i++) begin
      apply_stimulus("rnd", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 1023)), ($urandom_range(0, 5) != 0),
                     int'($urandom_range(1, 6)), lat);
    end

    // End-of-run state
    repeat (5) @(negedge clock);
    check_output("final_tone_ch0", 32'(psg_tone[0]), 32'(exp_tone[0]));
    check_output("final_tone_ch1", 32'(psg_tone[2]), 32'(exp_tone[1]));
    check_output("final_tone_ch2", 32'(psg_tone[1]), 32'(exp_tone[2]));
    check_output("final_done_count", 32'(done_cnt), 32'(exp_done_total));
    check_output("final_protocol", 32'(proto_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
